// File: rtl/pcie_ss_ctrl_bridge.sv
// pcie_ss_ctrl_bridge
// Turns the level-held SS_CMD/SS_DATA mailbox command from the PCIe CSR block into a
// single Avalon-MM-style access on the PCIe SS lite CSR port. It returns readdata, ack
// and error to the CSR block.
// Optional feature: define PCIE_SS_CTRL_TIMEOUT_EN to abandon an access that has been
// outstanding for TIMEOUT_CYCLES cycles. The access then completes with an error, and a
// read also returns all-ones.
module pcie_ss_ctrl_bridge #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_ctrl_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ctrl_addr,
    input  logic [DATA_WIDTH-1:0] i_ctrl_writedata,
    output logic [DATA_WIDTH-1:0] o_ctrl_readdata,
    output logic                  o_ctrl_ack,
    output logic                  o_ctrl_error,
    output logic                  o_ss_write,
    output logic                  o_ss_read,
    output logic [ADDR_WIDTH-1:0] o_ss_addr,
    output logic [DATA_WIDTH-1:0] o_ss_writedata,
    input  logic                  i_ss_waitrequest,
    input  logic [DATA_WIDTH-1:0] i_ss_readdata,
    input  logic                  i_ss_readdatavalid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              cmd_q;
    logic                    op_read;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    error_q;

    logic launch;
    logic accepted;
    logic rd_hit;
    logic normal_done;
    logic timeout;
    logic expire;

    // A launch needs a 00 -> nonzero edge on the command. cmd_q resets to 11, so a command
    // that is held across reset release does not relaunch.
    assign launch      = (state == IDLE) && (cmd_q == 2'b00) && (i_ctrl_cmd != 2'b00);
    assign accepted    = (state == REQ) && !i_ss_waitrequest;
    assign rd_hit      = op_read && i_ss_readdatavalid && (accepted || (state == RDWAIT));
    assign normal_done = (accepted && !op_read) || rd_hit;
    assign expire      = timeout && !normal_done;

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Count the cycles that the current access has spent waiting on the SS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (launch) begin
            to_cnt <= '0;
        end else if ((state == REQ) || (state == RDWAIT)) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign timeout = ((state == REQ) || (state == RDWAIT)) && (to_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Register the command every cycle so that launch edges can be detected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q <= 2'b11;
        end else begin
            cmd_q <= i_ctrl_cmd;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> REQ -> (RDWAIT) -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = (i_ctrl_cmd == 2'b11) ? DONE : REQ;
                end
            end
            REQ: begin
                if (normal_done || expire) begin
                    state_nxt = DONE;
                end else if (accepted) begin
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                if (normal_done || expire) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ctrl_cmd == 2'b00) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the access at launch, capture the read result and track the error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_read <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (launch) begin
            op_read <= (i_ctrl_cmd == 2'b10);
            addr_q  <= i_ctrl_addr;
            wdata_q <= i_ctrl_writedata;
            error_q <= (i_ctrl_cmd == 2'b11);
        end else if (rd_hit) begin
            rdata_q <= i_ss_readdata;
        end else if (expire) begin
            error_q <= 1'b1;
            if (op_read) begin
                rdata_q <= '1;
            end
        end
    end

    // Request and ack strobes are decoded from the state alone.
    always_comb begin
        o_ss_write = 1'b0;
        o_ss_read  = 1'b0;
        o_ctrl_ack = 1'b0;
        case (state)
            REQ: begin
                o_ss_write = !op_read;
                o_ss_read  = op_read;
            end
            DONE:    o_ctrl_ack = 1'b1;
            default: ;
        endcase
    end

    assign o_ss_addr       = addr_q;
    assign o_ss_writedata  = wdata_q;
    assign o_ctrl_readdata = rdata_q;
    assign o_ctrl_error    = error_q;

endmodule

// File: tb/tb_pcie_ss_ctrl_bridge.sv
// Testbench for pcie_ss_ctrl_bridge.
// Each mailbox transaction is planned up front: command, stall length, read latency and
// data. The expected output timeline for the transaction is then derived from that plan.
// A negedge process compares every output against the expected values on every cycle.
// Build with PCIE_SS_CTRL_TIMEOUT_EN defined to also exercise the timeout.
`timescale 1ns/1ps
module tb_pcie_ss_ctrl_bridge;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk                = 1'b0;
    logic          rst_n              = 1'b0;
    logic [1:0]    i_ctrl_cmd         = 2'b00;
    logic [AW-1:0] i_ctrl_addr        = '0;
    logic [DW-1:0] i_ctrl_writedata   = '0;
    logic          i_ss_waitrequest   = 1'b0;
    logic [DW-1:0] i_ss_readdata      = '0;
    logic          i_ss_readdatavalid = 1'b0;
    logic [DW-1:0] o_ctrl_readdata;
    logic          o_ctrl_ack;
    logic          o_ctrl_error;
    logic          o_ss_write;
    logic          o_ss_read;
    logic [AW-1:0] o_ss_addr;
    logic [DW-1:0] o_ss_writedata;

    pcie_ss_ctrl_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_ctrl_cmd         (i_ctrl_cmd),
        .i_ctrl_addr        (i_ctrl_addr),
        .i_ctrl_writedata   (i_ctrl_writedata),
        .o_ctrl_readdata    (o_ctrl_readdata),
        .o_ctrl_ack         (o_ctrl_ack),
        .o_ctrl_error       (o_ctrl_error),
        .o_ss_write         (o_ss_write),
        .o_ss_read          (o_ss_read),
        .o_ss_addr          (o_ss_addr),
        .o_ss_writedata     (o_ss_writedata),
        .i_ss_waitrequest   (i_ss_waitrequest),
        .i_ss_readdata      (i_ss_readdata),
        .i_ss_readdatavalid (i_ss_readdatavalid)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle.
    logic          exp_write = 1'b0;
    logic          exp_read  = 1'b0;
    logic          exp_ack   = 1'b0;
    logic          exp_err   = 1'b0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] exp_rdata = '0;

    int err_count   = 0;
    int check_count = 0;
    bit check_en    = 1'b0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
        check_count++;
        if (act !== req) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("ss_write",  64'(o_ss_write),      64'(exp_write));
        checkVal("ss_read",   64'(o_ss_read),       64'(exp_read));
        checkVal("ctrl_ack",  64'(o_ctrl_ack),      64'(exp_ack));
        checkVal("ctrl_err",  64'(o_ctrl_error),    64'(exp_err));
        checkVal("ss_addr",   64'(o_ss_addr),       64'(exp_addr));
        checkVal("ss_wdata",  64'(o_ss_writedata),  64'(exp_wdata));
        checkVal("rdata",     64'(o_ctrl_readdata), 64'(exp_rdata));
    endtask

    // Compare every output on every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    // Stop the run if the bench itself stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random SS-side activity that the bridge must ignore.
    task automatic noise();
        i_ss_waitrequest   = 1'($urandom_range(0, 1));
        i_ss_readdatavalid = 1'($urandom_range(0, 1));
        i_ss_readdata      = DW'($urandom);
    endtask

    // Runs one mailbox transaction. It is entered in a cycle where a launch is legal, and
    // it returns in such a cycle. n is the number of waitrequest stall cycles, and lat is
    // the number of cycles from acceptance to readdatavalid.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input int n, input int lat,
                                 input logic [DW-1:0] rd, input int hold, input int gap,
                                 input bit perturb, output int ack_lat, output int req_cnt);
        bit            is_read;
        bit            is_ill;
        bit            expired;
        int            done_at;
        int            req_last;
        int            ack_at;
        logic [DW-1:0] new_rdata;
        is_read  = (cmd == 2'b10);
        is_ill   = (cmd == 2'b11);
        expired  = 1'b0;
        done_at  = is_read ? (n + 1 + lat) : (n + 1);
        req_last = n + 1;
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
        if (!is_ill && done_at > TO) begin
            expired = 1'b1;
            done_at = TO;
            if (req_last > TO) req_last = TO;
        end
`endif
        if (is_ill) req_last = 0;
        ack_at    = is_ill ? 1 : done_at + 1;
        new_rdata = expired ? '1 : rd;
        ack_lat   = -1;
        req_cnt   = 0;
        i_ctrl_cmd       = cmd;
        i_ctrl_addr      = addr;
        i_ctrl_writedata = wd;
        noise();
        for (int k = 1; k <= ack_at + hold; k++) begin
            tick();
            exp_addr  = addr;
            exp_wdata = wd;
            exp_write = !is_read && !is_ill && (k <= req_last);
            exp_read  = is_read && (k <= req_last);
            exp_ack   = (k >= ack_at);
            exp_err   = (k >= ack_at) && (is_ill || expired);
            if (is_read && k == ack_at) exp_rdata = new_rdata;
            noise();
            if (!is_ill && k <= done_at) begin
                i_ss_waitrequest   = (k <= n);
                i_ss_readdatavalid = is_read && !expired && (k == done_at);
                if (is_read && k == done_at) i_ss_readdata = rd;
            end
            if (perturb) begin
                i_ctrl_addr      = AW'($urandom);
                i_ctrl_writedata = DW'($urandom);
                i_ctrl_cmd       = 2'($urandom_range(1, 3));
            end
            if (ack_lat < 0 && o_ctrl_ack === 1'b1) ack_lat = k;
            if (o_ss_write === 1'b1 || o_ss_read === 1'b1) req_cnt++;
        end
        // Drop the command. Ack is still high in this cycle and falls in the next one.
        tick();
        i_ctrl_cmd = 2'b00;
        noise();
        tick();
        exp_ack = 1'b0;
        noise();
        for (int g = 0; g < gap; g++) begin
            tick();
            noise();
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int r;
        logic [1:0] cmd;

        // Reset, then release it with the command idle.
        tick();
        check_en = 1'b1;
        tick();
        checkVal("reset_ack",   64'(o_ctrl_ack),      64'h0);
        checkVal("reset_rdata", 64'(o_ctrl_readdata), 64'h0);
        rst_n = 1'b1;
        tick();

        // Directed: plain write without stalls.
        applyStimulus(2'b01, 20'h00104, 32'hA5A5_0001, 0, 0, '0, 1, 0, 1'b0, lat, cnt);
        checkVal("t1_ack_latency", 64'(lat), 64'd2);
        checkVal("t1_req_cycles",  64'(cnt), 64'd1);
        checkVal("t1_ss_addr",     64'(o_ss_addr), 64'h00104);
        checkVal("t1_ss_wdata",    64'(o_ss_writedata), 64'hA5A5_0001);
        checkVal("t1_error",       64'(o_ctrl_error), 64'h0);

        // Directed: read with 3 stall cycles and data 4 cycles after acceptance.
        applyStimulus(2'b10, 20'h00200, 32'h0, 3, 4, 32'h1234_5678, 0, 1, 1'b0, lat, cnt);
        checkVal("t2_ack_latency", 64'(lat), 64'd9);
        checkVal("t2_req_cycles",  64'(cnt), 64'd4);
        checkVal("t2_rdata",       64'(o_ctrl_readdata), 64'h1234_5678);

        // Directed: illegal command, then a write that clears the error.
        applyStimulus(2'b11, 20'h00300, 32'h0, 0, 0, '0, 0, 0, 1'b0, lat, cnt);
        checkVal("t3_ack_latency", 64'(lat), 64'd1);
        checkVal("t3_req_cycles",  64'(cnt), 64'd0);
        checkVal("t3_error",       64'(o_ctrl_error), 64'h1);
        applyStimulus(2'b01, 20'h00304, 32'h0000_BEEF, 1, 0, '0, 0, 0, 1'b0, lat, cnt);
        checkVal("t3_error_clear", 64'(o_ctrl_error), 64'h0);
        checkVal("t3_rdata_kept",  64'(o_ctrl_readdata), 64'h1234_5678);

        // Directed: command held and changed between nonzero values after ack.
        applyStimulus(2'b10, 20'h00400, 32'h0, 0, 1, 32'hCAFE_0004, 6, 0, 1'b1, lat, cnt);
        checkVal("t4_ack_latency", 64'(lat), 64'd3);
        checkVal("t4_req_cycles",  64'(cnt), 64'd1);

        // Random transactions.
        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 9);
            cmd = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
            applyStimulus(cmd, AW'($urandom), DW'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 4), DW'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, cnt);
        end

        // Directed: reset while waiting for read data, and a command held through reset.
        i_ctrl_cmd       = 2'b10;
        i_ctrl_addr      = 20'h00ABC;
        i_ctrl_writedata = 32'h5555_0000;
        noise();
        tick();
        exp_addr  = 20'h00ABC;
        exp_wdata = 32'h5555_0000;
        exp_read  = 1'b1;
        exp_err   = 1'b0;
        i_ss_waitrequest   = 1'b0;
        i_ss_readdatavalid = 1'b0;
        tick();
        exp_read = 1'b0;
        i_ss_readdatavalid = 1'b0;
        tick();
        rst_n      = 1'b0;
        i_ctrl_cmd = 2'b01;
        i_ss_readdatavalid = 1'b0;
        tick();
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        exp_ack   = 1'b0;
        exp_read  = 1'b0;
        exp_write = 1'b0;
        rst_n = 1'b1;
        i_ss_readdatavalid = 1'b1;
        i_ss_readdata      = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            tick();
            noise();
        end
        checkVal("t5_rdata", 64'(o_ctrl_readdata), 64'h0);
        checkVal("t5_ack",   64'(o_ctrl_ack),      64'h0);
        checkVal("t5_write", 64'(o_ss_write),      64'h0);
        i_ctrl_cmd = 2'b00;
        tick();
        noise();

        applyStimulus(2'b10, 20'h00500, 32'h0, 0, 2, 32'h0BAD_F00D, 0, 0, 1'b0, lat, cnt);
        checkVal("t5_after_rdata", 64'(o_ctrl_readdata), 64'h0BAD_F00D);

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
        // Directed: read with waitrequest stuck high until the timeout fires.
        applyStimulus(2'b10, 20'h00600, 32'h0, 40, 0, 32'h0, 0, 0, 1'b0, lat, cnt);
        checkVal("t6_ack_latency", 64'(lat), 64'd17);
        checkVal("t6_rdata",       64'(o_ctrl_readdata), 64'hFFFF_FFFF);
        checkVal("t6_error",       64'(o_ctrl_error), 64'h1);
`endif

        tick();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
